// File: rtl/reflet_uart_loader_pkg.sv
// Shared types and helpers for the Reflet UART boot loader.
package reflet_uart_loader_pkg;

  // Loader progress through a length-prefixed image
  typedef enum logic [1:0] {
    LEN_LO  = 2'd0,
    LEN_HI  = 2'd1,
    PAYLOAD = 2'd2,
    DONE    = 2'd3
  } load_state_t;

  // Byte receiver phases
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Clock cycles per UART bit (integer floor)
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/reflet_uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, baud counter and receive FSM.
module reflet_uart_rx_byte
  import reflet_uart_loader_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned DIV = calc_div(clk_freq, baud_rate);
  localparam int CW = $clog2(DIV + 1);
  // Counter counts down to zero, so loading N-1 gives an N-cycle interval
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

  rx_state_t     state;
  rx_state_t     state_next;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_done;

  assign cnt_done  = (cnt == '0);
  assign byte_data = shreg;

  // Receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  // Receiver next-state: start is re-checked at mid-bit to reject glitches
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
      RX_START: if (cnt_done) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_done && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (cnt_done) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Receiver outputs: the stop-bit sample decides between a good byte and a framing error
  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (state == RX_STOP && cnt_done) begin
      byte_valid = rx_sync;
      frame_err  = !rx_sync;
    end
  end

  // Synchronizer, baud counter and LSB-first shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (state)
        RX_IDLE: begin
          cnt     <= HALF_LOAD;
          bit_idx <= '0;
        end
        RX_DATA: begin
          if (cnt_done) begin
            cnt     <= FULL_LOAD;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (cnt_done) cnt <= FULL_LOAD;
          else          cnt <= cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reflet_uart_loader.sv
// UART boot loader: receives a length-prefixed image and writes it to instruction RAM.
module reflet_uart_loader
  import reflet_uart_loader_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600,
  parameter int unsigned addr_size = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [addr_size-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 mem_write_en,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error
);

  load_state_t          state;
  load_state_t          state_next;
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 frame_err;
  logic [7:0]           len_lo;
  logic [15:0]          remaining;
  logic [15:0]          length;
  logic [addr_size-1:0] wr_ptr;
  logic                 full;
  logic                 take_payload;
  logic                 do_write;
  logic                 do_ovf;

  reflet_uart_rx_byte #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign length = {byte_data, len_lo};

  // Loader state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LEN_LO;
    else       state <= state_next;
  end

  // Loader next-state: a zero length skips the payload entirely
  always_comb begin
    state_next = state;
    case (state)
      LEN_LO:  if (byte_valid) state_next = LEN_HI;
      LEN_HI:  if (byte_valid) state_next = (length == 16'd0) ? DONE : PAYLOAD;
      PAYLOAD: if (byte_valid && remaining == 16'd1) state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  // Loader decode: once the RAM is full, payload bytes are consumed without a write
  always_comb begin
    take_payload = (state == PAYLOAD) && byte_valid;
    do_write     = take_payload && !full;
    do_ovf       = take_payload && full;
  end

  // Counters, RAM write port and sticky status; done lags the last strobe by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo       <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      full         <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_write_en <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_write_en <= do_write;
      done         <= (state == DONE);
      cpu_hold     <= (state != DONE);
      if (state == LEN_LO && byte_valid) len_lo <= byte_data;
      if (state == LEN_HI && byte_valid) begin
        remaining <= length;
        wr_ptr    <= '0;
        full      <= 1'b0;
      end
      if (take_payload) remaining <= remaining - 16'd1;
      if (do_write) begin
        mem_addr <= wr_ptr;
        mem_data <= byte_data;
        // Park at the top address instead of wrapping
        if (wr_ptr == '1) full <= 1'b1;
        else              wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_ovf || (frame_err && state != DONE)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reflet_uart_loader.sv
// Directed bench for the UART boot loader (default instance plus a 4-byte-RAM instance).
`timescale 1ns/1ps
module tb_reflet_uart_loader;

  localparam int DIV = 104;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;

  logic [14:0] mem_addr0;
  logic [7:0]  mem_data0;
  logic        we0, hold0, done0, err0;
  logic [1:0]  mem_addr1;
  logic [7:0]  mem_data1;
  logic        we1, hold1, done1, err1;

  int total = 0;
  int bad = 0;

  // strobe logs
  int          n0 = 0;
  int          n1 = 0;
  logic [14:0] a0 [0:15];
  logic [7:0]  d0 [0:15];
  logic [1:0]  a1 [0:15];
  logic [7:0]  d1 [0:15];
  longint      cyc = 0;
  longint      last_we0 = 0;
  longint      done_rise0 = 0;
  int          b2b = 0;
  logic        we0_d = 1'b0;
  logic        we1_d = 1'b0;
  logic        done0_d = 1'b0;

  reflet_uart_loader #(.clk_freq(1000000), .baud_rate(9600), .addr_size(15)) u0 (
    .clk(clk), .reset(reset), .rx(rx0),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_write_en(we0),
    .cpu_hold(hold0), .done(done0), .error(err0)
  );

  reflet_uart_loader #(.clk_freq(1000000), .baud_rate(9600), .addr_size(2)) u1 (
    .clk(clk), .reset(reset), .rx(rx1),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_write_en(we1),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  always #500 clk = ~clk;

  // log write strobes away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we0) begin
      if (n0 < 16) begin a0[n0] = mem_addr0; d0[n0] = mem_data0; end
      n0 = n0 + 1;
      last_we0 = cyc;
      if (we0_d) b2b = b2b + 1;
    end
    if (we1) begin
      if (n1 < 16) begin a1[n1] = mem_addr1; d1[n1] = mem_data1; end
      n1 = n1 + 1;
      if (we1_d) b2b = b2b + 1;
    end
    if (done0 && !done0_d) done_rise0 = cyc;
    we0_d = we0;
    we1_d = we1;
    done0_d = done0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one 8N1 frame; a low stop bit is followed by a full idle bit so the next start edge exists
  task automatic send(input int which, input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (which == 0) rx0 = fr[i]; else rx1 = fr[i];
      tick(DIV);
    end
    if (which == 0) rx0 = 1'b1; else rx1 = 1'b1;
    tick(stop_bit ? 4 : DIV);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    n0 = 0;
    n1 = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 32'(mem_addr0), 32'h0);
    chk({tag, "_data"}, 32'(mem_data0), 32'h0);
    chk({tag, "_we"},   32'(we0),       32'h0);
    chk({tag, "_hold"}, 32'(hold0),     32'h1);
    chk({tag, "_done"}, 32'(done0),     32'h0);
    chk({tag, "_err"},  32'(err0),      32'h0);
  endtask

  initial begin
    // reset state
    tick(3);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;
    n0 = 0;

    // basic 3-byte image
    send(0, 8'h03, 1'b1); send(0, 8'h00, 1'b1);
    send(0, 8'hAA, 1'b1); send(0, 8'hBB, 1'b1); send(0, 8'hCC, 1'b1);
    $display("txn basic: writes=%0d done=%0b hold=%0b err=%0b", n0, done0, hold0, err0);
    chk("basic_count", 32'(n0), 32'd3);
    chk("basic_a0", 32'(a0[0]), 32'd0); chk("basic_d0", 32'(d0[0]), 32'hAA);
    chk("basic_a1", 32'(a0[1]), 32'd1); chk("basic_d1", 32'(d0[1]), 32'hBB);
    chk("basic_a2", 32'(a0[2]), 32'd2); chk("basic_d2", 32'(d0[2]), 32'hCC);
    chk("basic_done", 32'(done0), 32'h1);
    chk("basic_hold", 32'(hold0), 32'h0);
    chk("basic_err", 32'(err0), 32'h0);
    chk("basic_done_lag", 32'(done_rise0 - last_we0), 32'd1);

    // zero-length image
    pulse_reset();
    send(0, 8'h00, 1'b1); send(0, 8'h00, 1'b1);
    $display("txn zero_len: writes=%0d done=%0b", n0, done0);
    chk("zero_count", 32'(n0), 32'd0);
    chk("zero_done", 32'(done0), 32'h1);
    chk("zero_hold", 32'(hold0), 32'h0);
    chk("zero_err", 32'(err0), 32'h0);

    // framing error mid-payload
    pulse_reset();
    send(0, 8'h03, 1'b1); send(0, 8'h00, 1'b1);
    send(0, 8'hAA, 1'b1);
    send(0, 8'h55, 1'b0);
    $display("txn frame_err: writes=%0d addr=%0h err=%0b", n0, mem_addr0, err0);
    chk("fe_err", 32'(err0), 32'h1);
    chk("fe_count", 32'(n0), 32'd1);
    chk("fe_addr", 32'(mem_addr0), 32'd0);
    chk("fe_done", 32'(done0), 32'h0);
    send(0, 8'hBB, 1'b1); send(0, 8'hCC, 1'b1);
    $display("txn frame_err_resend: writes=%0d done=%0b", n0, done0);
    chk("fe_count2", 32'(n0), 32'd3);
    chk("fe_a1", 32'(a0[1]), 32'd1); chk("fe_d1", 32'(d0[1]), 32'hBB);
    chk("fe_a2", 32'(a0[2]), 32'd2); chk("fe_d2", 32'(d0[2]), 32'hCC);
    chk("fe_done2", 32'(done0), 32'h1);

    // reset mid-load
    pulse_reset();
    send(0, 8'h04, 1'b1); send(0, 8'h00, 1'b1);
    send(0, 8'h11, 1'b1); send(0, 8'h22, 1'b1);
    $display("txn partial: writes=%0d addr=%0h", n0, mem_addr0);
    chk("mid_count", 32'(n0), 32'd2);
    chk("mid_addr", 32'(mem_addr0), 32'd1);
    chk("mid_data", 32'(mem_data0), 32'h22);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick(2);
    @(negedge clk);
    reset = 1'b0;
    n0 = 0;
    send(0, 8'h04, 1'b1); send(0, 8'h00, 1'b1);
    send(0, 8'hA1, 1'b1); send(0, 8'hB2, 1'b1); send(0, 8'hC3, 1'b1); send(0, 8'hD4, 1'b1);
    $display("txn reload: writes=%0d done=%0b", n0, done0);
    chk("rl_count", 32'(n0), 32'd4);
    chk("rl_a0", 32'(a0[0]), 32'd0); chk("rl_d0", 32'(d0[0]), 32'hA1);
    chk("rl_a3", 32'(a0[3]), 32'd3); chk("rl_d3", 32'(d0[3]), 32'hD4);
    chk("rl_done", 32'(done0), 32'h1);

    // short low glitch must not be taken as a byte
    pulse_reset();
    rx0 = 1'b0;
    tick(DIV / 4);
    rx0 = 1'b1;
    tick(2 * DIV);
    chk("gl_err", 32'(err0), 32'h0);
    send(0, 8'h01, 1'b1); send(0, 8'h00, 1'b1); send(0, 8'h5A, 1'b1);
    $display("txn glitch: writes=%0d done=%0b err=%0b", n0, done0, err0);
    chk("gl_count", 32'(n0), 32'd1);
    chk("gl_a0", 32'(a0[0]), 32'd0);
    chk("gl_d0", 32'(d0[0]), 32'h5A);
    chk("gl_done", 32'(done0), 32'h1);
    chk("gl_err2", 32'(err0), 32'h0);

    // overflow on the 4-byte RAM instance
    pulse_reset();
    send(1, 8'h06, 1'b1); send(1, 8'h00, 1'b1);
    send(1, 8'h11, 1'b1); send(1, 8'h22, 1'b1); send(1, 8'h33, 1'b1);
    send(1, 8'h44, 1'b1); send(1, 8'h55, 1'b1); send(1, 8'h66, 1'b1);
    $display("txn overflow: writes=%0d addr=%0h done=%0b err=%0b", n1, mem_addr1, done1, err1);
    chk("ov_count", 32'(n1), 32'd4);
    chk("ov_a0", 32'(a1[0]), 32'd0); chk("ov_d0", 32'(d1[0]), 32'h11);
    chk("ov_a3", 32'(a1[3]), 32'd3); chk("ov_d3", 32'(d1[3]), 32'h44);
    chk("ov_addr", 32'(mem_addr1), 32'd3);
    chk("ov_data", 32'(mem_data1), 32'h44);
    chk("ov_err", 32'(err1), 32'h1);
    chk("ov_done", 32'(done1), 32'h1);
    chk("ov_hold", 32'(hold1), 32'h0);

    chk("no_back_to_back", 32'(b2b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reflet_uart_loader.md
# reflet_uart_loader

UART boot loader that sits upstream of the CPU's instruction memory in the Reflet microcontroller. Out of reset it holds the CPU in reset and receives a length-prefixed program image on `rx`. It writes each byte sequentially into instruction RAM, then releases the CPU. It replaces the fixed ROM image for board bring-up without resynthesis.

## Interface
- `clk_freq`, 1000000: system clock frequency in Hz.
- `baud_rate`, 9600: UART bit rate.
- `addr_size`, 15: instruction-RAM address width, i.e. capacity of 2^addr_size bytes.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART line: 8N1, LSB first, idle high, asynchronous to `clk`.
- `mem_addr`  out  addr_size  instruction-RAM write address.
- `mem_data`  out  8  instruction-RAM write data.
- `mem_write_en`  out  1  single-cycle write strobe.
- `cpu_hold`  out  1  high keeps the CPU in reset; ORed into the CPU reset by the top level.
- `done`  out  1  image fully loaded; sticky until `reset`.
- `error`  out  1  framing or overflow error seen during the current load; sticky until `reset`.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- Bit period is `DIV = clk_freq / baud_rate`, using integer floor. Example: 104 for the defaults.
- Byte receiver states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on a falling edge of synced `rx`, load the counter with DIV/2 and go to START.
  - START: at the counter's end, if `rx` is still low, go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, one every DIV cycles.
  - STOP: sample once. If high, emit `byte_valid` for one cycle. If low, set `error`, discard the byte and return to IDLE.
- Loader FSM states: LEN_LO → LEN_HI → PAYLOAD → DONE.
  - LEN_LO: the first valid byte is length[7:0].
  - LEN_HI: the next valid byte is length[15:8]. If the 16-bit length is 0, go directly to DONE. Otherwise go to PAYLOAD with the address counter at 0 and the remaining count equal to length.
  - PAYLOAD: for each valid byte, drive `mem_data` = byte and `mem_addr` = counter, and pulse `mem_write_en`. Then increment the address and decrement the remaining count. When the remaining count reaches 0, go to DONE.
  - DONE: `done` = 1 and `cpu_hold` = 0. Further `rx` traffic is ignored.
- Overflow: if length exceeds 2^addr_size, bytes whose index is at least 2^addr_size are still consumed and counted but not written (no strobe). `error` is set on the first such byte. The address does not wrap.
- A framing error discards only the byte in error. The loader keeps waiting, so the host must resend that byte.
- `reset` at any point aborts the load:
  - all state returns to LEN_LO/IDLE;
  - `cpu_hold` = 1;
  - previously written RAM contents are left untouched.

## Timing
- Reset values:
  - `mem_addr` = 0, `mem_data` = 0, `mem_write_en` = 0;
  - `cpu_hold` = 1, `done` = 0, `error` = 0.
- Stop-bit sample to `mem_write_en` is 1 cycle. `mem_addr` and `mem_data` are valid in the same cycle as the strobe and hold until the next strobe.
- `mem_write_en` is never high for two consecutive cycles.
- `done` rises and `cpu_hold` falls in the cycle after the final strobe. For length 0, this happens in the cycle after the LEN_HI byte is accepted.
- `rx` edge to sampled start bit is 2 cycles of synchronizer latency plus DIV/2.
- Bytes sent back-to-back at `baud_rate` with tolerance of ±2% must be accepted. The receiver is back in IDLE before the next start bit.

## Structure
- Shared package holds:
  - the loader state encoding (LEN_LO, LEN_HI, PAYLOAD, DONE);
  - the receiver state encoding;
  - the function computing DIV from `clk_freq` and `baud_rate`.
- One sub-module: `reflet_uart_rx_byte`, containing the synchronizer, the baud counter and the receiver FSM. Its outputs are `byte_valid`, `byte_data` and `frame_err`.
- The top of the block holds the loader FSM, the address counter, the remaining counter and the sticky flags.

## Test plan
- Defaults, send 0x03 0x00 0xAA 0xBB 0xCC. Expect:
  - exactly three strobes, writing addr 0/1/2 with data 0xAA/0xBB/0xCC;
  - `done` = 1 and `cpu_hold` = 0 one cycle after the third strobe;
  - `error` = 0.
- Send 0x00 0x00. Expect no strobes, and `done` = 1 one cycle after the second byte.
- Send a frame with the stop bit low in the middle of the payload. Expect `error` = 1, that byte not written, and the address unchanged. The next good byte is written at the same address.
- `addr_size` = 2, send length 0x0006 plus 6 bytes. Expect:
  - addresses 0–3 written;
  - 2 bytes consumed without a strobe;
  - `error` = 1 and `done` = 1.
- Assert `reset` after 2 payload bytes of a 4-byte image. Expect all outputs at their reset values immediately. A full resend then loads addresses from 0.
- Hold `rx` low for DIV/4 cycles, then high. Expect no byte accepted and no `error`.
